ext_pipe: RTL and testbench

Parametrised, buffered immediate/load-data extension unit for the pipelined CPU. It widens an immediate or a sub-word memory read to `DATA_W` bits using one of eight extension modes, then queues the result in a `DEPTH`-entry FIFO with valid/ready handshakes on both sides. It sits between the decode/memory stage and its consumer, so that a stalled consumer does not lose extended operands. Every result has one cycle of latency.

---
 rtl/ext_pipe.sv | 163 ++++++++++++++++
 tb/tb_ext_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// Purpose : widen an immediate or sub-word load to DATA_W bits (8 modes) and queue the result.
// Latency : 1 cycle, push at edge N is visible on out_data/out_valid in cycle N+1.
// Backpr. : DEPTH-entry FIFO; in_ready = not full (registered only), out_data holds while stalled.
//
// Ports:
//   clk, reset_n (async active-low), flush (sync clear of the queue)
//   in_valid/in_ready/in_op/in_imm/in_word/in_off : producer side, extension computed at push
//   out_valid/out_ready/out_data                   : consumer side, head of the FIFO
//   out_err                                        : misaligned halfword flag (EXT_ALIGN_CHECK_EN only)
//
// Optional feature macro: EXT_ALIGN_CHECK_EN
module ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 2,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_word,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef EXT_ALIGN_CHECK_EN
    ,
    output logic              out_err
`endif
);

    // A single-entry FIFO still needs a one-bit pointer to keep the declarations legal.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_IMM_ZX = 3'd0,
        OP_IMM_SX = 3'd1,
        OP_LUI    = 3'd2,
        OP_LB     = 3'd3,
        OP_LBU    = 3'd4,
        OP_LH     = 3'd5,
        OP_LHU    = 3'd6,
        OP_PASS   = 3'd7
    } ext_op_e;

    // ------------------------------------------------------------------
    // Extension datapath (combinational, input side)
    // ------------------------------------------------------------------
    logic [OFF_W+2:0]  byte_bit;
    logic [OFF_W+2:0]  half_bit;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ext_dat;
    logic              ext_err;

    always_comb begin
        byte_bit = {in_off, 3'b000};
        // Halfwords are always taken from an even byte offset.
        half_bit = {in_off[OFF_W-1:1], 1'b0, 3'b000};
        byte_v   = in_word[byte_bit +: 8];
        half_v   = in_word[half_bit +: 16];
        ext_dat  = '0;
        unique case (ext_op_e'(in_op))
            OP_IMM_ZX: ext_dat = {{(DATA_W-IMM_W){1'b0}}, in_imm};
            OP_IMM_SX: ext_dat = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
            OP_LUI:    ext_dat = DATA_W'(in_imm) << IMM_W;
            OP_LB:     ext_dat = {{(DATA_W-8){byte_v[7]}}, byte_v};
            OP_LBU:    ext_dat = {{(DATA_W-8){1'b0}}, byte_v};
            OP_LH:     ext_dat = {{(DATA_W-16){half_v[15]}}, half_v};
            OP_LHU:    ext_dat = {{(DATA_W-16){1'b0}}, half_v};
            OP_PASS:   ext_dat = in_word;
            default:   ext_dat = '0;
        endcase
        ext_err = ((in_op == OP_LH) || (in_op == OP_LHU)) && in_off[0];
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    logic [DATA_W-1:0] mem_q [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Both flags derive from the registered count, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            // Flush wins over any handshake in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= ext_dat;
        end
    end

`ifdef EXT_ALIGN_CHECK_EN
    logic err_q [DEPTH];

    assign out_err = err_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) err_q[i] <= 1'b0;
        end else if (push && !flush) begin
            err_q[wr_ptr_q] <= ext_err;
        end
    end
`else
    // Without the check a misaligned halfword is silently aligned down.
    logic unused_err;
    assign unused_err = ext_err;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Purpose : scoreboard bench for ext_pipe (DATA_W=32, IMM_W=16, DEPTH=2).
// Latency : expectations queued at the accepting edge, compared one cycle later.
// Backpr. : bench drives out_ready directly to exercise full/stall/flush cases.
module tb_ext_pipe;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int DEPTH  = 2;
    localparam int OFF_W  = 2;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [IMM_W-1:0]  in_imm;
    logic [DATA_W-1:0] in_word;
    logic [OFF_W-1:0]  in_off;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef EXT_ALIGN_CHECK_EN
    logic              out_err;
`endif

    ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .in_word   (in_word),
        .in_off    (in_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef EXT_ALIGN_CHECK_EN
        ,
        .out_err   (out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              e;
    } exp_t;

    exp_t sb[$];
    logic [DATA_W-1:0] exp_dat;
    logic              exp_err;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: checks flags against the model, compares the head, then
    // retires/records the handshakes the next rising edge will perform.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
            if (out_valid && sb.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(sb[0].d));
`ifdef EXT_ALIGN_CHECK_EN
                chk("out_err", 64'(out_err), 64'(sb[0].e));
`endif
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
                if (in_valid && in_ready) sb.push_back({exp_dat, exp_err});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] word,
                         input logic [1:0] off, input logic [31:0] ed, input logic ee);
        in_valid = 1'b1;
        in_op    = op;
        in_imm   = imm;
        in_word  = word;
        in_off   = off;
        exp_dat  = ed;
        exp_err  = ee;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 64'(out_valid), 64'(0));
    endtask

    localparam logic [31:0] W = 32'h80FF7F01;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_imm    = '0;
        in_word   = '0;
        in_off    = '0;
        out_ready = 1'b1;
        exp_dat   = '0;
        exp_err   = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_data", 64'(out_data), 64'(0));
`ifdef EXT_ALIGN_CHECK_EN
        chk("rst_out_err", 64'(out_err), 64'(0));
`endif
        #20 reset_n = 1'b1;
        cyc();

        // Mode sweep, one beat per cycle, consumer always ready.
        offer(3'd0, 16'h8001, '0, 2'd0, 32'h00008001, 1'b0); cyc();
        offer(3'd1, 16'h8001, '0, 2'd0, 32'hFFFF8001, 1'b0); cyc();
        offer(3'd2, 16'h8001, '0, 2'd0, 32'h80010000, 1'b0); cyc();
        offer(3'd1, 16'h7FFF, '0, 2'd0, 32'h00007FFF, 1'b0); cyc();
        offer(3'd3, 16'h0000, W,  2'd2, 32'hFFFFFFFF, 1'b0); cyc();
        offer(3'd4, 16'h0000, W,  2'd2, 32'h000000FF, 1'b0); cyc();
        offer(3'd3, 16'h0000, W,  2'd3, 32'hFFFFFF80, 1'b0); cyc();
        offer(3'd3, 16'h0000, W,  2'd1, 32'h0000007F, 1'b0); cyc();
        offer(3'd5, 16'h0000, W,  2'd2, 32'hFFFF80FF, 1'b0); cyc();
        offer(3'd6, 16'h0000, W,  2'd0, 32'h00007F01, 1'b0); cyc();
        offer(3'd6, 16'h0000, W,  2'd3, 32'h000080FF, 1'b1); cyc();
        offer(3'd7, 16'h0000, W,  2'd1, 32'h80FF7F01, 1'b0); cyc();
        drain();

        // Backpressure: A and B fill the FIFO, C is refused.
        out_ready = 1'b0;
        offer(3'd0, 16'h000A, '0, 2'd0, 32'h0000000A, 1'b0); cyc();
        offer(3'd0, 16'h000B, '0, 2'd0, 32'h0000000B, 1'b0); cyc();
        chk("full_in_ready", 64'(in_ready), 64'(0));
        offer(3'd0, 16'h000C, '0, 2'd0, 32'h0000000C, 1'b0); cyc(); cyc();
        chk("full_hold_data", 64'(out_data), 64'(32'h0000000A));
        idle();
        out_ready = 1'b1;
        cyc();
        chk("after_pop_in_ready", 64'(in_ready), 64'(1));
        chk("after_pop_data", 64'(out_data), 64'(32'h0000000B));
        drain();

        // Simultaneous push/pop at count 1 for 10 cycles.
        out_ready = 1'b0;
        offer(3'd0, 16'h0100, '0, 2'd0, 32'h00000100, 1'b0); cyc();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            offer(3'd0, 16'(16'h0100 + i), '0, 2'd0, 32'(32'h100 + i), 1'b0);
            cyc();
            chk("steady_count1", 64'({out_valid, in_ready}), 64'(2'b11));
        end
        drain();

        // Flush while full with a beat offered.
        out_ready = 1'b0;
        offer(3'd0, 16'h00F1, '0, 2'd0, 32'h000000F1, 1'b0); cyc();
        offer(3'd0, 16'h00F2, '0, 2'd0, 32'h000000F2, 1'b0); cyc();
        offer(3'd0, 16'h00F3, '0, 2'd0, 32'h000000F3, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        // Flush at count 1 with a push that would otherwise be accepted.
        out_ready = 1'b1;
        offer(3'd0, 16'h00F4, '0, 2'd0, 32'h000000F4, 1'b0); cyc();
        offer(3'd0, 16'h00F5, '0, 2'd0, 32'h000000F5, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("flush2_out_valid", 64'(out_valid), 64'(0));
        cyc();

        // Asynchronous reset between edges with two entries queued.
        out_ready = 1'b0;
        offer(3'd0, 16'h00E1, '0, 2'd0, 32'h000000E1, 1'b0); cyc();
        offer(3'd0, 16'h00E2, '0, 2'd0, 32'h000000E2, 1'b0); cyc();
        idle();
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_out_data", 64'(out_data), 64'(0));
        #1 reset_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        offer(3'd5, 16'h0000, W, 2'd1, 32'h00007F01, 1'b1); cyc();
        idle();
        chk("post_rst_valid", 64'(out_valid), 64'(1));
        chk("post_rst_data", 64'(out_data), 64'(32'h00007F01));
        drain();
        cyc();
        chk("final_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
